// File: rtl/bht_maint_scheduler_if.sv
// BHT maintenance bus: EX update and flush request inputs, plus the BHT read/write port.
// The master side is the pipeline/BHT environment. The slave side is the scheduler.
interface bht_maint_scheduler_if #(
    parameter int IDX_W = 6
);
    logic             upd_valid;
    logic [IDX_W-1:0] upd_index;
    logic             upd_taken;
    logic             upd_predicted;
    logic             flush_req;
    logic [IDX_W-1:0] bht_rd_index;
    logic [1:0]       bht_rd_data;
    logic             bht_we;
    logic [IDX_W-1:0] bht_wr_index;
    logic [1:0]       bht_wr_data;

    modport master (
        output upd_valid, upd_index, upd_taken, upd_predicted, flush_req, bht_rd_data,
        input  bht_rd_index, bht_we, bht_wr_index, bht_wr_data
    );

    modport slave (
        input  upd_valid, upd_index, upd_taken, upd_predicted, flush_req, bht_rd_data,
        output bht_rd_index, bht_we, bht_wr_index, bht_wr_data
    );
endinterface

// File: rtl/bht_maint_scheduler.sv
// Arbitrates the single BHT write port between three sources:
//   - the flush sweep,
//   - EX resolution updates (saturating 2-bit step),
//   - the periodic ageing sweep.
// It also keeps saturating update statistics.
module bht_maint_scheduler #(
    parameter int         ENTRIES    = 64,
    parameter int         IDX_W      = 6,
    parameter logic [1:0] INIT_STATE = 2'b10,
    parameter int         AGE_PERIOD = 256,
    parameter int         CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    bht_maint_scheduler_if.slave  bus,
    output logic                  busy,
    output logic [CNT_W-1:0]      total_updates,
    output logic [CNT_W-1:0]      mispredicts,
    output logic [CNT_W-1:0]      dropped_updates
);
    localparam int               AGE_W    = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);
    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'((AGE_PERIOD > 0) ? AGE_PERIOD - 1 : 0);

    typedef enum logic [1:0] {IDLE, FLUSH, AGE} state_t;

    state_t           state, state_nx;
    logic [IDX_W-1:0] sweep_ptr, ptr_nx;
    logic [AGE_W-1:0] age_cnt, age_nx;
    logic [CNT_W-1:0] tot_nx, mis_nx, drop_nx;
    logic             applied;
    logic             age_trig;
    logic             sweep_end;

    function automatic logic [1:0] sat_step(input logic [1:0] s, input logic taken);
        if (taken) return (s == 2'b11) ? s : s + 2'b01;
        else       return (s == 2'b00) ? s : s - 2'b01;
    endfunction

    function automatic logic [1:0] age_map(input logic [1:0] s);
        case (s)
            2'b11:   return 2'b10;
            2'b00:   return 2'b01;
            default: return s;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    // State, sweep pointer, ageing counter and statistics registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            sweep_ptr       <= '0;
            age_cnt         <= '0;
            total_updates   <= '0;
            mispredicts     <= '0;
            dropped_updates <= '0;
        end else begin
            state           <= state_nx;
            sweep_ptr       <= ptr_nx;
            age_cnt         <= age_nx;
            total_updates   <= tot_nx;
            mispredicts     <= mis_nx;
            dropped_updates <= drop_nx;
        end
    end

    // Write-port arbitration and next-state logic
    always_comb begin
        state_nx         = state;
        ptr_nx           = sweep_ptr;
        age_nx           = age_cnt;
        tot_nx           = total_updates;
        mis_nx           = mispredicts;
        drop_nx          = dropped_updates;
        applied          = 1'b0;
        age_trig         = 1'b0;
        bus.bht_we       = 1'b0;
        bus.bht_wr_index = '0;
        bus.bht_wr_data  = '0;
        bus.bht_rd_index = bus.upd_valid ? bus.upd_index : sweep_ptr;
        sweep_end        = (sweep_ptr == LAST_IDX);

        case (state)
            FLUSH: begin
                bus.bht_we       = 1'b1;
                bus.bht_wr_index = sweep_ptr;
                bus.bht_wr_data  = INIT_STATE;
                ptr_nx           = sweep_end ? '0 : sweep_ptr + IDX_W'(1);
                if (sweep_end) state_nx = IDLE;
                if (bus.upd_valid) drop_nx = bump(dropped_updates);
            end
            AGE: begin
                // An update steals the port, so the sweep pointer holds and no entry is skipped
                if (bus.upd_valid) begin
                    applied = 1'b1;
                end else begin
                    bus.bht_we       = 1'b1;
                    bus.bht_wr_index = sweep_ptr;
                    bus.bht_wr_data  = age_map(bus.bht_rd_data);
                    ptr_nx           = sweep_end ? '0 : sweep_ptr + IDX_W'(1);
                    if (sweep_end) state_nx = IDLE;
                end
            end
            default: begin
                if (bus.upd_valid) applied = 1'b1;
            end
        endcase

        if (applied) begin
            bus.bht_we       = 1'b1;
            bus.bht_wr_index = bus.upd_index;
            bus.bht_wr_data  = sat_step(bus.bht_rd_data, bus.upd_taken);
            tot_nx           = bump(total_updates);
            if (bus.upd_predicted != bus.upd_taken) mis_nx = bump(mispredicts);
            if (AGE_PERIOD != 0) begin
                if (age_cnt == AGE_LAST) begin
                    age_nx   = '0;
                    age_trig = 1'b1;
                end else begin
                    age_nx = age_cnt + AGE_W'(1);
                end
            end
        end

        if (age_trig && state == IDLE) state_nx = AGE;

        if (bus.flush_req) begin
            state_nx = FLUSH;
            ptr_nx   = '0;
            age_nx   = '0;
        end

        if (reset) begin
            bus.bht_we       = 1'b0;
            bus.bht_wr_index = '0;
            bus.bht_wr_data  = '0;
        end

        busy = (state != IDLE);
    end
endmodule

// File: tb/tb_bht_maint_scheduler.sv
// Directed bench for bht_maint_scheduler.
// A behavioural BHT array sits on the read/write port. Single-update vectors come from a table.
// Flush, ageing, abort and reset-mid-sweep are hand-written sequences.
module tb_bht_maint_scheduler;
    localparam int ENTRIES = 64;
    localparam int IDX_W   = 6;
    localparam int CNT_W   = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             busy;
    logic [CNT_W-1:0] total_updates, mispredicts, dropped_updates;
    logic [1:0]       mem [ENTRIES];
    logic [1:0]       preload [ENTRIES];
    logic             load_req = 1'b0;
    int               n_cmp = 0;
    int               n_err = 0;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [1:0]       rd;
        logic             taken;
        logic             pred;
        logic [1:0]       wr;
        logic [31:0]      mis;
    } vec_t;

    vec_t tbl [8];

    bht_maint_scheduler_if #(.IDX_W(IDX_W)) bus ();

    bht_maint_scheduler #(
        .ENTRIES(ENTRIES), .IDX_W(IDX_W), .INIT_STATE(2'b10), .AGE_PERIOD(4), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus.slave), .busy(busy),
        .total_updates(total_updates), .mispredicts(mispredicts), .dropped_updates(dropped_updates)
    );

    always #5 clk = ~clk;

    assign bus.bht_rd_data = mem[bus.bht_rd_index];

    // BHT array: bulk image load, otherwise written by the scheduler
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < ENTRIES; i++) mem[i] <= preload[i];
        end else if (bus.bht_we) begin
            mem[bus.bht_wr_index] <= bus.bht_wr_data;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_in();
        bus.upd_valid     = 1'b0;
        bus.upd_index     = '0;
        bus.upd_taken     = 1'b0;
        bus.upd_predicted = 1'b0;
        bus.flush_req     = 1'b0;
    endtask

    task automatic upd(input logic [IDX_W-1:0] idx, input logic taken, input logic pred);
        bus.upd_valid     = 1'b1;
        bus.upd_index     = idx;
        bus.upd_taken     = taken;
        bus.upd_predicted = pred;
        bus.flush_req     = 1'b0;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_in();
        reset    = 1'b1;
        load_req = 1'b1;
        next_cyc();
        load_req = 1'b0;
        reset    = 1'b0;
    endtask

    task automatic set_pattern();
        for (int i = 0; i < ENTRIES; i++) preload[i] = 2'(i);
    endtask

    initial begin
        logic [1:0] exp_age [4];
        logic [1:0] tk [4];
        int ptr, ncyc, bad;
        logic injected;

        tbl[0] = '{6'd5,  2'b10, 1'b1, 1'b0, 2'b11, 32'd1};
        tbl[1] = '{6'd7,  2'b00, 1'b0, 1'b0, 2'b00, 32'd0};
        tbl[2] = '{6'd9,  2'b11, 1'b1, 1'b1, 2'b11, 32'd0};
        tbl[3] = '{6'd3,  2'b01, 1'b1, 1'b1, 2'b10, 32'd0};
        tbl[4] = '{6'd63, 2'b10, 1'b0, 1'b1, 2'b01, 32'd1};
        tbl[5] = '{6'd0,  2'b01, 1'b0, 1'b0, 2'b00, 32'd0};
        tbl[6] = '{6'd12, 2'b11, 1'b0, 1'b1, 2'b10, 32'd1};
        tbl[7] = '{6'd40, 2'b00, 1'b1, 1'b0, 2'b01, 32'd1};
        exp_age[0] = 2'b10; exp_age[1] = 2'b01; exp_age[2] = 2'b01; exp_age[3] = 2'b10;

        // Reset state
        set_pattern();
        do_reset();
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_total", total_updates, 0);
        chk("rst_mis", mispredicts, 0);
        chk("rst_drop", dropped_updates, 0);
        chk("rst_we", 32'(bus.bht_we), 0);
        chk("rst_rd_index", 32'(bus.bht_rd_index), 0);
        next_cyc();

        // Single updates from the table
        for (int k = 0; k < 8; k++) begin
            preload[tbl[k].idx] = tbl[k].rd;
            do_reset();
            upd(tbl[k].idx, tbl[k].taken, tbl[k].pred);
            @(negedge clk);
            chk("vec_we", 32'(bus.bht_we), 1);
            chk("vec_wr_index", 32'(bus.bht_wr_index), 32'(tbl[k].idx));
            chk("vec_rd_index", 32'(bus.bht_rd_index), 32'(tbl[k].idx));
            chk("vec_wr_data", 32'(bus.bht_wr_data), 32'(tbl[k].wr));
            next_cyc();
            idle_in();
            @(negedge clk);
            chk("vec_total", total_updates, 1);
            chk("vec_mis", mispredicts, tbl[k].mis);
            chk("vec_bht", 32'(mem[tbl[k].idx]), 32'(tbl[k].wr));
            next_cyc();
        end

        // Back-to-back updates to one index see the freshly written value
        preload[20] = 2'b00;
        do_reset();
        upd(6'd20, 1'b1, 1'b1);
        @(negedge clk);
        chk("b2b_first", 32'(bus.bht_wr_data), 32'(2'b01));
        next_cyc();
        upd(6'd20, 1'b1, 1'b1);
        @(negedge clk);
        chk("b2b_second", 32'(bus.bht_wr_data), 32'(2'b10));
        next_cyc();
        idle_in();
        @(negedge clk);
        chk("b2b_total", total_updates, 2);
        next_cyc();

        // Full flush with a dropped update at sweep index 10
        set_pattern();
        do_reset();
        bus.flush_req = 1'b1;
        @(negedge clk);
        chk("flush_req_we", 32'(bus.bht_we), 0);
        next_cyc();
        for (int i = 0; i < ENTRIES; i++) begin
            if (i == 10) upd(6'd5, 1'b1, 1'b0); else idle_in();
            @(negedge clk);
            if (i == 0) chk("flush_busy", 32'(busy), 1);
            chk("flush_we", 32'(bus.bht_we), 1);
            chk("flush_idx", 32'(bus.bht_wr_index), 32'(i));
            chk("flush_data", 32'(bus.bht_wr_data), 32'(2'b10));
            next_cyc();
        end
        idle_in();
        @(negedge clk);
        chk("flush_done_busy", 32'(busy), 0);
        chk("flush_done_we", 32'(bus.bht_we), 0);
        chk("flush_dropped", dropped_updates, 1);
        chk("flush_total", total_updates, 0);
        bad = 0;
        for (int i = 0; i < ENTRIES; i++) if (mem[i] !== 2'b10) bad++;
        chk("flush_fill_bad", 32'(bad), 0);
        next_cyc();

        // Reset in the middle of a flush
        do_reset();
        bus.flush_req = 1'b1;
        next_cyc();
        for (int i = 0; i < 31; i++) begin
            if (i == 5) upd(6'd7, 1'b0, 1'b1); else idle_in();
            @(negedge clk);
            if (i < 30) next_cyc();
        end
        chk("midflush_idx", 32'(bus.bht_wr_index), 30);
        chk("midflush_drop", dropped_updates, 1);
        reset = 1'b1;
        #1;
        chk("midrst_we", 32'(bus.bht_we), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_drop", dropped_updates, 0);
        next_cyc();
        reset = 1'b0;
        idle_in();
        @(negedge clk);
        chk("postrst_busy", 32'(busy), 0);
        chk("postrst_ptr", 32'(bus.bht_rd_index), 0);
        chk("postrst_we", 32'(bus.bht_we), 0);
        next_cyc();

        // Ageing after four updates, with one update stealing the port at sweep index 10
        set_pattern();
        preload[0] = 2'b11; preload[1] = 2'b00; preload[2] = 2'b01; preload[3] = 2'b10;
        preload[50] = 2'b10; preload[60] = 2'b00;
        tk[0] = 1'b1; tk[1] = 1'b1; tk[2] = 1'b0; tk[3] = 1'b0;
        do_reset();
        for (int u = 0; u < 4; u++) begin
            upd(6'd50, tk[u], tk[u]);
            @(negedge clk);
            if (u == 3) chk("age_pre_busy", 32'(busy), 0);
            next_cyc();
        end
        ptr = 0; ncyc = 0; injected = 1'b0;
        while (1) begin
            if (ptr == 10 && !injected) upd(6'd60, 1'b1, 1'b1); else idle_in();
            @(negedge clk);
            if (!busy) break;
            if (ncyc == 0) chk("age_entered", 32'(busy), 1);
            ncyc++;
            if (bus.upd_valid) begin
                injected = 1'b1;
                chk("age_upd_idx", 32'(bus.bht_wr_index), 60);
                chk("age_upd_data", 32'(bus.bht_wr_data), 32'(2'b01));
            end else begin
                chk("age_idx", 32'(bus.bht_wr_index), 32'(ptr));
                if (ptr < 4) chk("age_data", 32'(bus.bht_wr_data), 32'(exp_age[ptr]));
                ptr++;
            end
            next_cyc();
            if (ncyc > 200) begin
                chk("age_timeout", 32'(ncyc), 65);
                break;
            end
        end
        chk("age_cycles", 32'(ncyc), 65);
        chk("age_ptr_end", 32'(ptr), 64);
        chk("age_total", total_updates, 5);
        bad = 0;
        for (int i = 0; i < ENTRIES; i++) if (mem[i] !== 2'b01 && mem[i] !== 2'b10) bad++;
        chk("age_strong_left", 32'(bad), 0);
        for (int i = 0; i < 4; i++) chk("age_mem", 32'(mem[i]), 32'(exp_age[i]));
        next_cyc();

        // Flush request aborts an ageing sweep at index 20
        set_pattern();
        preload[50] = 2'b10;
        do_reset();
        for (int u = 0; u < 4; u++) begin
            upd(6'd50, 1'b1, (u == 0) ? 1'b0 : 1'b1);
            @(negedge clk);
            next_cyc();
        end
        for (int i = 0; i <= 20; i++) begin
            idle_in();
            if (i == 20) bus.flush_req = 1'b1;
            @(negedge clk);
            if (i == 20) chk("abort_age_idx", 32'(bus.bht_wr_index), 20);
            next_cyc();
        end
        idle_in();
        ncyc = 0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 1);
        chk("abort_idx", 32'(bus.bht_wr_index), 0);
        chk("abort_data", 32'(bus.bht_wr_data), 32'(2'b10));
        chk("abort_total", total_updates, 4);
        chk("abort_mis", mispredicts, 1);
        chk("abort_drop", dropped_updates, 0);
        while (busy && ncyc < 100) begin
            ncyc++;
            next_cyc();
            @(negedge clk);
        end
        chk("abort_flush_len", 32'(ncyc), 64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
